// File: rtl/system_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : system_sysid_checker
// Purpose  : Avalon-MM read master that fetches the system ID (word 0) and
//            build timestamp (word 1), compares them with build-time values
//            and reports pass/fail with a per-read timeout.
// Revision : 1.0 - initial release
// ============================================================================
module system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1392333275,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_ID = 3'd1,
    S_LAT_ID = 3'd2,
    S_REQ_TS = 3'd3,
    S_LAT_TS = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  // With zero latency the data is taken in the accepting cycle itself.
  localparam bit          LAT_ZERO = (READ_LATENCY == 0);
  // Value of the latency counter in the cycle that carries valid readdata.
  localparam logic [1:0]  LAT_LAST = 2'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);
  // Value of the timeout counter in the last cycle a read may still finish.
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        addr_q, addr_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  logic in_req, in_lat, is_ts, capture, to_hit;

  // Transaction qualifiers derived from the current state.
  always_comb begin
    in_req  = (state_q == S_REQ_ID) || (state_q == S_REQ_TS);
    in_lat  = (state_q == S_LAT_ID) || (state_q == S_LAT_TS);
    is_ts   = (state_q == S_REQ_TS) || (state_q == S_LAT_TS);
    capture = (in_req && !avm_waitrequest && LAT_ZERO) ||
              (in_lat && (lat_cnt_q == LAT_LAST));
    to_hit  = (in_req || in_lat) && (to_cnt_q == TO_LAST);
  end

  // Next-state, counter and result computation; a capture beats a timeout.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    to_cnt_d   = to_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;

    if (in_req || in_lat) begin
      to_cnt_d = to_cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_REQ_ID;
          addr_d    = 1'b0;
          to_cnt_d  = 16'd0;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_REQ_ID, S_REQ_TS: begin
        if (!avm_waitrequest) begin
          lat_cnt_d = 2'd0;
          if (!LAT_ZERO) begin
            state_d = (state_q == S_REQ_ID) ? S_LAT_ID : S_LAT_TS;
          end
        end
      end
      S_LAT_ID, S_LAT_TS: begin
        lat_cnt_d = lat_cnt_q + 2'd1;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (capture) begin
      if (is_ts) begin
        ts_value_d = avm_readdata;
        ts_ok_d    = (avm_readdata == EXPECTED_TIMESTAMP);
        state_d    = S_FIN;
      end else begin
        id_value_d = avm_readdata;
        id_ok_d    = (avm_readdata == EXPECTED_ID);
        state_d    = S_REQ_TS;
        addr_d     = 1'b1;
        to_cnt_d   = 16'd0;
      end
    end else if (to_hit) begin
      timeout_d = 1'b1;
      state_d   = S_FIN;
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= 1'b0;
      to_cnt_q   <= 16'd0;
      lat_cnt_q  <= 2'd0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      to_cnt_q   <= to_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  assign avm_read    = in_req;
  assign avm_address = addr_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule
`default_nettype wire

// File: tb/tb_system_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_system_sysid_checker
// Purpose  : Randomized bench for system_sysid_checker; two instances
//            (latency 0 and latency 2) against a slave model and a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_system_sysid_checker;

  localparam int          TO         = 8;
  localparam logic [31:0] EXP_ID     = 32'd0;
  localparam logic [31:0] EXP_TS     = 32'd1392333275;
  localparam int          NUM_CHECKS = 60;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start [2];
  logic        rd    [2];
  logic        addr  [2];
  logic        wr    [2];
  logic [31:0] rdata [2];
  logic        busy  [2];
  logic        done  [2];
  logic        id_ok [2];
  logic        ts_ok [2];
  logic        tmo   [2];
  logic [31:0] idv   [2];
  logic [31:0] tsv   [2];

  always #5 clock = ~clock;

  system_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
    .READ_LATENCY(0), .TIMEOUT_CYCLES(TO)
  ) u_dut_l0 (
    .clock(clock), .reset(reset), .start(start[0]),
    .avm_address(addr[0]), .avm_read(rd[0]), .avm_waitrequest(wr[0]),
    .avm_readdata(rdata[0]), .busy(busy[0]), .done(done[0]),
    .id_ok(id_ok[0]), .ts_ok(ts_ok[0]), .timeout(tmo[0]),
    .id_value(idv[0]), .ts_value(tsv[0])
  );

  system_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
    .READ_LATENCY(2), .TIMEOUT_CYCLES(TO)
  ) u_dut_l2 (
    .clock(clock), .reset(reset), .start(start[1]),
    .avm_address(addr[1]), .avm_read(rd[1]), .avm_waitrequest(wr[1]),
    .avm_readdata(rdata[1]), .busy(busy[1]), .done(done[1]),
    .id_ok(id_ok[1]), .ts_ok(ts_ok[1]), .timeout(tmo[1]),
    .id_value(idv[1]), .ts_value(tsv[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  // Slave model state.
  int          stall_left [2];
  int          pend       [2];
  logic        pend_addr  [2];
  logic        acc        [2];
  logic        acc_addr   [2];
  // Per-check stimulus.
  int          s0 [2];
  int          s1 [2];
  int          xs [2];
  logic [31:0] id_data [2];
  logic [31:0] ts_data [2];
  // Reference model results.
  int          e_done   [2];
  int          e_r0_end [2];
  int          e_r1_lo  [2];
  int          e_r1_hi  [2];
  logic        e_id_ok  [2];
  logic        e_ts_ok  [2];
  logic        e_tmo    [2];
  logic [31:0] e_idv    [2];
  logic [31:0] e_tsv    [2];
  logic [31:0] prev_idv [2];
  logic [31:0] prev_tsv [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Transaction-level model: a read with s stall cycles needs s+1+L cycles
  // to deliver data; more than TO cycles means it is aborted.
  task automatic model(input int k);
    int n0, n1;
    n0          = s0[k] + 1 + lat_of(k);
    e_id_ok[k]  = 1'b0;
    e_ts_ok[k]  = 1'b0;
    e_tmo[k]    = 1'b0;
    e_idv[k]    = prev_idv[k];
    e_tsv[k]    = prev_tsv[k];
    e_r0_end[k] = min2(s0[k] + 1, TO);
    e_r1_lo[k]  = 0;
    e_r1_hi[k]  = -1;
    if (n0 > TO) begin
      e_tmo[k]  = 1'b1;
      e_done[k] = TO + 1;
    end else begin
      e_idv[k]   = id_data[k];
      e_id_ok[k] = (id_data[k] == EXP_ID);
      n1         = s1[k] + 1 + lat_of(k);
      e_r1_lo[k] = n0 + 1;
      e_r1_hi[k] = n0 + min2(s1[k] + 1, TO);
      if (n1 > TO) begin
        e_tmo[k]  = 1'b1;
        e_done[k] = n0 + TO + 1;
      end else begin
        e_tsv[k]   = ts_data[k];
        e_ts_ok[k] = (ts_data[k] == EXP_TS);
        e_done[k]  = n0 + n1 + 1;
      end
    end
  endtask

  // Called at a negedge: drive slave responses, advance one clock.
  task automatic drive_cycle();
    for (int k = 0; k < 2; k++) begin
      logic valid;
      logic a;
      valid = 1'b0;
      a     = 1'b0;
      if (lat_of(k) == 0) begin
        if (rd[k] && stall_left[k] == 0) begin
          valid = 1'b1;
          a     = addr[k];
        end
      end else if (pend[k] > 0) begin
        pend[k]--;
        if (pend[k] == 0) begin
          valid = 1'b1;
          a     = pend_addr[k];
        end
      end
      wr[k]       = rd[k] && (stall_left[k] > 0);
      rdata[k]    = valid ? (a ? ts_data[k] : id_data[k]) : $urandom;
      acc[k]      = rd[k] && !wr[k];
      acc_addr[k] = addr[k];
    end
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      if (wr[k]) stall_left[k]--;
      if (acc[k]) begin
        stall_left[k] = s1[k];
        pend[k]       = lat_of(k);
        pend_addr[k]  = acc_addr[k];
      end
    end
    @(negedge clock);
  endtask

  function automatic logic [31:0] pick_data(input logic [31:0] good);
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return good ^ (32'd1 << $urandom_range(0, 31));
    if (r == 1) return $urandom;
    return good;
  endfunction

  initial begin
    int cmax;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; wr[k] = 1'b0; rdata[k] = 32'd0;
      stall_left[k] = 0; pend[k] = 0; pend_addr[k] = 1'b0;
      prev_idv[k] = 32'd0; prev_tsv[k] = 32'd0;
      id_data[k] = EXP_ID; ts_data[k] = EXP_TS; s0[k] = 0; s1[k] = 0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("rst_ctl", {57'd0, rd[k], addr[k], busy[k], done[k], id_ok[k], ts_ok[k], tmo[k]}, 64'd0);
      check("rst_val", {idv[k], tsv[k]}, 64'd0);
    end

    for (int t = 0; t < NUM_CHECKS; t++) begin
      for (int k = 0; k < 2; k++) begin
        id_data[k] = EXP_ID;
        ts_data[k] = EXP_TS;
        xs[k]      = 0;
        if (t == 0) begin
          s0[k] = (k == 0) ? 0 : 3;
          s1[k] = 0;
        end else if (t == 1) begin
          s0[k]      = (k == 0) ? 0 : 20;
          s1[k]      = 0;
          ts_data[k] = EXP_TS ^ 32'd1;
        end else begin
          s0[k] = ($urandom_range(0, 9) == 0) ? 30 : $urandom_range(0, 9);
          s1[k] = ($urandom_range(0, 9) == 0) ? 30 : $urandom_range(0, 9);
          id_data[k] = pick_data(EXP_ID);
          ts_data[k] = pick_data(EXP_TS);
        end
        model(k);
        if (t == 1) xs[k] = (k == 0) ? 2 : e_done[k];
        else if (t > 1 && $urandom_range(0, 1) == 1) xs[k] = $urandom_range(1, e_done[k]);
      end

      cmax = ((e_done[0] > e_done[1]) ? e_done[0] : e_done[1]) + 2;
      for (int k = 0; k < 2; k++) begin
        start[k]      = 1'b1;
        stall_left[k] = s0[k];
        pend[k]       = 0;
      end
      drive_cycle();

      for (int c = 1; c <= cmax; c++) begin
        for (int k = 0; k < 2; k++) begin
          logic er, ea;
          er = (c >= 1 && c <= e_r0_end[k]) || (c >= e_r1_lo[k] && c <= e_r1_hi[k]);
          ea = (c >= e_r1_lo[k] && c <= e_r1_hi[k]);
          check($sformatf("bus%0d_t%0d_c%0d", k, t, c),
                {60'd0, rd[k], rd[k] ? addr[k] : 1'b0, busy[k], done[k]},
                {60'd0, er, ea, (c >= 1 && c <= e_done[k]), (c == e_done[k])});
          if (c == 1) check($sformatf("clr%0d_t%0d", k, t), {61'd0, id_ok[k], ts_ok[k], tmo[k]}, 64'd0);
          start[k] = (xs[k] == c);
        end
        drive_cycle();
      end

      for (int k = 0; k < 2; k++) begin
        start[k] = 1'b0;
        check($sformatf("flags%0d_t%0d", k, t), {61'd0, id_ok[k], ts_ok[k], tmo[k]},
              {61'd0, e_id_ok[k], e_ts_ok[k], e_tmo[k]});
        check($sformatf("vals%0d_t%0d", k, t), {idv[k], tsv[k]}, {e_idv[k], e_tsv[k]});
        prev_idv[k] = e_idv[k];
        prev_tsv[k] = e_tsv[k];
      end
    end

    // Reset while the latency-2 instance sits in its ID latency phase.
    for (int k = 0; k < 2; k++) begin
      s0[k] = 0; s1[k] = 0; id_data[k] = EXP_ID; ts_data[k] = EXP_TS;
      start[k] = 1'b1; stall_left[k] = 0; pend[k] = 0;
    end
    drive_cycle();
    start[0] = 1'b0;
    start[1] = 1'b0;
    drive_cycle();
    reset = 1'b1;
    drive_cycle();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("mid_rst_ctl%0d", k),
            {57'd0, rd[k], addr[k], busy[k], done[k], id_ok[k], ts_ok[k], tmo[k]}, 64'd0);
      check($sformatf("mid_rst_val%0d", k), {idv[k], tsv[k]}, 64'd0);
      stall_left[k] = 0;
      pend[k]       = 0;
    end
    for (int c = 0; c < 12; c++) begin
      drive_cycle();
      for (int k = 0; k < 2; k++) begin
        check($sformatf("post_rst%0d_c%0d", k, c), {61'd0, rd[k], busy[k], done[k]}, 64'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
